// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the Tnew/Tuse hazard unit and the pipeline registers
// that carry the Tnew/Tuse fields.
package hazard_ctrl_pkg;

  localparam int TNEW_W = 4;

  typedef logic [TNEW_W-1:0] tnew_t;
  typedef logic [4:0]        reg_addr_t;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_sel_e;

  // Tuse code written by a pipeline register on reset: the operand is not read.
  localparam tnew_t DEF_TUSE_NONE   = tnew_t'(4);
  localparam int    DEF_MULT_CYCLES = 5;
  localparam int    DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the datapath (master) and the hazard unit (slave): D-stage
// operand fields, E/M/W producer fields, HI/LO issue, and the control results.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  reg_addr_t   rs_addr_D;
  reg_addr_t   rt_addr_D;
  tnew_t       rs_use_D;
  tnew_t       rt_use_D;
  logic        md_use_D;
  reg_addr_t   dst_addr_E;
  reg_addr_t   dst_addr_M;
  reg_addr_t   dst_addr_W;
  tnew_t       dst_save_E;
  tnew_t       dst_save_M;
  tnew_t       dst_save_W;
  logic        md_start_E;
  logic        md_is_div_E;
  logic        stall;
  logic        flush_E;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic        md_busy;
  logic [31:0] stall_count;

  modport master (
    output rs_addr_D, rt_addr_D, rs_use_D, rt_use_D, md_use_D,
           dst_addr_E, dst_addr_M, dst_addr_W,
           dst_save_E, dst_save_M, dst_save_W,
           md_start_E, md_is_div_E,
    input  stall, flush_E, fwd_rs_sel, fwd_rt_sel, md_busy, stall_count
  );

  modport slave (
    input  rs_addr_D, rt_addr_D, rs_use_D, rt_use_D, md_use_D,
           dst_addr_E, dst_addr_M, dst_addr_W,
           dst_save_E, dst_save_M, dst_save_W,
           md_start_E, md_is_div_E,
    output stall, flush_E, fwd_rs_sel, fwd_rt_sel, md_busy, stall_count
  );

endinterface

// File: rtl/hazard_operand_resolve.sv
// Resolves one D-stage source operand against the E/M/W producers: either a
// forwarding select or a data stall.
module hazard_operand_resolve
  import hazard_ctrl_pkg::*;
#(
  parameter tnew_t TUSE_NONE = DEF_TUSE_NONE
) (
  input  reg_addr_t addr_i,
  input  tnew_t     use_i,
  input  reg_addr_t eAddr_i,
  input  tnew_t     eSave_i,
  input  reg_addr_t mAddr_i,
  input  tnew_t     mSave_i,
  input  reg_addr_t wAddr_i,
  input  tnew_t     wSave_i,
  output fwd_sel_e  sel_o,
  output logic      stall_o
);

  // The youngest matching producer decides; addr_i != 0 already excludes $0 producers.
  always_comb begin
    sel_o   = FWD_GRF;
    stall_o = 1'b0;
    if (addr_i != 5'd0 && use_i != TUSE_NONE) begin
      if (eAddr_i == addr_i) begin
        if (eSave_i > use_i)        stall_o = 1'b1;
        else if (eSave_i == '0)     sel_o   = FWD_E;
      end else if (mAddr_i == addr_i) begin
        if (mSave_i > use_i)        stall_o = 1'b1;
        else if (mSave_i == '0)     sel_o   = FWD_M;
      end else if (wAddr_i == addr_i) begin
        if (wSave_i > use_i)        stall_o = 1'b1;
        else if (wSave_i == '0)     sel_o   = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit: data stalls and forwarding selects from Tnew/Tuse fields, the
// HI/LO busy counter, and a saturating stalled-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int    MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int    DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter tnew_t TUSE_NONE   = DEF_TUSE_NONE
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = $clog2(MD_MAX + 1);

  logic [CNT_W-1:0] mdCount_q, mdCount_d;
  logic [31:0]      stallCount_q, stallCount_d;
  fwd_sel_e         rsSel, rtSel;
  logic             rsStall, rtStall;
  logic             mdBusy, stallRaw;

  hazard_operand_resolve #(.TUSE_NONE(TUSE_NONE)) uRsResolve (
    .addr_i (hz.rs_addr_D),
    .use_i  (hz.rs_use_D),
    .eAddr_i(hz.dst_addr_E),
    .eSave_i(hz.dst_save_E),
    .mAddr_i(hz.dst_addr_M),
    .mSave_i(hz.dst_save_M),
    .wAddr_i(hz.dst_addr_W),
    .wSave_i(hz.dst_save_W),
    .sel_o  (rsSel),
    .stall_o(rsStall)
  );

  hazard_operand_resolve #(.TUSE_NONE(TUSE_NONE)) uRtResolve (
    .addr_i (hz.rt_addr_D),
    .use_i  (hz.rt_use_D),
    .eAddr_i(hz.dst_addr_E),
    .eSave_i(hz.dst_save_E),
    .mAddr_i(hz.dst_addr_M),
    .mSave_i(hz.dst_save_M),
    .wAddr_i(hz.dst_addr_W),
    .wSave_i(hz.dst_save_W),
    .sel_o  (rtSel),
    .stall_o(rtStall)
  );

  // The start term covers the cycle before the counter has loaded.
  assign mdBusy   = (mdCount_q != '0) | hz.md_start_E;
  assign stallRaw = rsStall | rtStall | (hz.md_use_D & mdBusy);

  always_comb begin
    hz.stall       = reset ? 1'b0 : stallRaw;
    hz.flush_E     = reset ? 1'b0 : stallRaw;
    hz.fwd_rs_sel  = reset ? FWD_GRF : rsSel;
    hz.fwd_rt_sel  = reset ? FWD_GRF : rtSel;
    hz.md_busy     = mdBusy;
    hz.stall_count = stallCount_q;
  end

  // A start while the counter is running cannot legally happen and is dropped.
  always_comb begin
    mdCount_d = mdCount_q;
    if (hz.md_start_E && mdCount_q == '0)
      mdCount_d = hz.md_is_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (mdCount_q != '0)
      mdCount_d = mdCount_q - 1'b1;
  end

  always_comb begin
    stallCount_d = stallCount_q;
    if (stallRaw && stallCount_q != 32'hFFFF_FFFF)
      stallCount_d = stallCount_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mdCount_q    <= '0;
      stallCount_q <= '0;
    end else begin
      mdCount_q    <= mdCount_d;
      stallCount_q <= stallCount_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed Tnew/Tuse and HI/LO scenarios
// plus randomized traffic against a cycle-level reference model.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MULT_N = DEF_MULT_CYCLES;
  localparam int DIV_N  = DEF_DIV_CYCLES;

  typedef struct {
    logic       rst;
    logic [4:0] rsA, rtA, eA, mA, wA;
    logic [3:0] rsU, rtU, eS, mS, wS;
    logic       mdUse, mdStart, mdDiv;
  } stim_t;

  logic clk;
  logic reset;
  hazard_ctrl_if hzIf ();

  hazard_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hzIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: cycle number, last cycle the HI/LO unit is busy, stall count.
  longint cycleNo  = 0;
  longint busyEnd  = -1;
  longint expCount = 0;

  logic        obsStall, obsBusy;
  logic [1:0]  obsRsSel, obsRtSel;
  logic [31:0] obsCount;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycleNo);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.rst = 1'b0;
    s.rsA = '0; s.rtA = '0; s.eA = '0; s.mA = '0; s.wA = '0;
    s.rsU = DEF_TUSE_NONE; s.rtU = DEF_TUSE_NONE;
    s.eS = '0; s.mS = '0; s.wS = '0;
    s.mdUse = 1'b0; s.mdStart = 1'b0; s.mdDiv = 1'b0;
    return s;
  endfunction

  // Scan producers youngest-first; the first register match decides the operand.
  function automatic void resolveRef(input logic [4:0] a, input logic [3:0] u, input stim_t s,
                                     output int sel, output bit stl);
    logic [4:0] pa[3];
    logic [3:0] ps[3];
    pa[0] = s.eA; pa[1] = s.mA; pa[2] = s.wA;
    ps[0] = s.eS; ps[1] = s.mS; ps[2] = s.wS;
    sel = 0;
    stl = 1'b0;
    if (a == 5'd0 || u == DEF_TUSE_NONE) return;
    for (int i = 0; i < 3; i++) begin
      if (pa[i] == a) begin
        if (ps[i] > u)       stl = 1'b1;
        else if (ps[i] == 0) sel = i + 1;
        return;
      end
    end
  endfunction

  // Drive one cycle, check every output at the falling edge, advance the model at the rising edge.
  task automatic applyStimulus(input stim_t s);
    int  rsSelExp, rtSelExp;
    bit  rsStl, rtStl, busyExp, stallExp;
    reset = s.rst;
    hzIf.rs_addr_D = s.rsA;   hzIf.rt_addr_D = s.rtA;
    hzIf.rs_use_D = s.rsU;    hzIf.rt_use_D = s.rtU;
    hzIf.md_use_D = s.mdUse;
    hzIf.dst_addr_E = s.eA;   hzIf.dst_save_E = s.eS;
    hzIf.dst_addr_M = s.mA;   hzIf.dst_save_M = s.mS;
    hzIf.dst_addr_W = s.wA;   hzIf.dst_save_W = s.wS;
    hzIf.md_start_E = s.mdStart;
    hzIf.md_is_div_E = s.mdDiv;

    resolveRef(s.rsA, s.rsU, s, rsSelExp, rsStl);
    resolveRef(s.rtA, s.rtU, s, rtSelExp, rtStl);
    busyExp  = s.mdStart || (cycleNo <= busyEnd);
    stallExp = !s.rst && (rsStl || rtStl || (s.mdUse && busyExp));
    if (s.rst) begin
      rsSelExp = 0;
      rtSelExp = 0;
    end

    @(negedge clk);
    obsStall = hzIf.stall;
    obsBusy  = hzIf.md_busy;
    obsRsSel = hzIf.fwd_rs_sel;
    obsRtSel = hzIf.fwd_rt_sel;
    obsCount = hzIf.stall_count;
    checkOutput("stall", {31'd0, obsStall}, {31'd0, stallExp});
    checkOutput("flush_E", {31'd0, hzIf.flush_E}, {31'd0, stallExp});
    checkOutput("md_busy", {31'd0, obsBusy}, {31'd0, busyExp});
    if (!stallExp) begin
      checkOutput("fwd_rs_sel", {30'd0, obsRsSel}, rsSelExp);
      checkOutput("fwd_rt_sel", {30'd0, obsRtSel}, rtSelExp);
    end
    if (cycleNo > 0) checkOutput("stall_count", obsCount, expCount[31:0]);

    @(posedge clk);
    if (s.rst) begin
      busyEnd  = -1;
      expCount = 0;
    end else begin
      if (s.mdStart && !(cycleNo <= busyEnd))
        busyEnd = cycleNo + (s.mdDiv ? DIV_N : MULT_N);
      if (stallExp && expCount < 64'hFFFF_FFFF) expCount++;
    end
    cycleNo++;
    #1;
  endtask

  task automatic resetCycle();
    stim_t s;
    s = idleStim();
    s.rst = 1'b1;
    applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    int    stallCycles;

    resetCycle();
    resetCycle();
    checkOutput("reset_count", obsCount, 32'd0);
    checkOutput("reset_busy", {31'd0, obsBusy}, 32'd0);

    // lw in E feeding a Tuse=1 consumer, then walking down to W.
    s = idleStim();
    s.eA = 5'd8; s.eS = 4'd2; s.rsA = 5'd8; s.rsU = 4'd1;
    applyStimulus(s);
    checkOutput("lwE_stall", {31'd0, obsStall}, 32'd1);
    s = idleStim();
    s.mA = 5'd8; s.mS = 4'd1; s.rsA = 5'd8; s.rsU = 4'd0;
    applyStimulus(s);
    checkOutput("lwM_stall", {31'd0, obsStall}, 32'd1);
    s = idleStim();
    s.wA = 5'd8; s.wS = 4'd0; s.rsA = 5'd8; s.rsU = 4'd1;
    applyStimulus(s);
    checkOutput("lwW_stall", {31'd0, obsStall}, 32'd0);
    checkOutput("lwW_sel", {30'd0, obsRsSel}, 32'd3);

    // ALU chain: E wins over an equally ready M producer.
    s = idleStim();
    s.eA = 5'd5; s.eS = 4'd0; s.rtA = 5'd5; s.rtU = 4'd1;
    applyStimulus(s);
    checkOutput("aluE_sel", {30'd0, obsRtSel}, 32'd1);
    s.mA = 5'd5; s.mS = 4'd0;
    applyStimulus(s);
    checkOutput("aluEprio_sel", {30'd0, obsRtSel}, 32'd1);
    checkOutput("aluEprio_stall", {31'd0, obsStall}, 32'd0);

    // $0 operand and unused operand never forward or stall.
    s = idleStim();
    s.rsA = 5'd0; s.rsU = 4'd1; s.eA = 5'd0; s.eS = 4'd0;
    s.rtA = 5'd5; s.rtU = DEF_TUSE_NONE; s.mA = 5'd5; s.mS = 4'd0;
    applyStimulus(s);
    checkOutput("zeroReg_sel", {30'd0, obsRsSel}, 32'd0);
    checkOutput("noUse_sel", {30'd0, obsRtSel}, 32'd0);
    checkOutput("zeroNoUse_stall", {31'd0, obsStall}, 32'd0);

    // div followed by mflo: stalled for the start cycle plus DIV_N.
    resetCycle();
    s = idleStim();
    s.mdStart = 1'b1; s.mdDiv = 1'b1; s.mdUse = 1'b1;
    applyStimulus(s);
    checkOutput("divStart_busy", {31'd0, obsBusy}, 32'd1);
    stallCycles = obsStall ? 1 : 0;
    s.mdStart = 1'b0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(s);
      if (!obsStall) break;
      stallCycles++;
    end
    checkOutput("div_stallCycles", stallCycles, DIV_N + 1);
    checkOutput("div_stallCount", obsCount, DIV_N + 1);

    // Reset while the divide counter holds 6.
    resetCycle();
    s = idleStim();
    s.mdStart = 1'b1; s.mdDiv = 1'b1; s.mdUse = 1'b1;
    applyStimulus(s);
    s.mdStart = 1'b0;
    for (int i = 0; i < DIV_N - 6; i++) applyStimulus(s);
    s.rst = 1'b1;
    applyStimulus(s);
    s.rst = 1'b0;
    applyStimulus(s);
    checkOutput("rstDiv_busy", {31'd0, obsBusy}, 32'd0);
    checkOutput("rstDiv_stall", {31'd0, obsStall}, 32'd0);
    checkOutput("rstDiv_count", obsCount, 32'd0);

    // Saturation: preload the counter just below the ceiling, then stall.
    force dut.stallCount_q = 32'hFFFF_FFFD;
    #1;
    release dut.stallCount_q;
    expCount = 64'hFFFF_FFFD;
    s = idleStim();
    s.eA = 5'd9; s.eS = 4'd2; s.rsA = 5'd9; s.rsU = 4'd0;
    for (int i = 0; i < 5; i++) applyStimulus(s);
    applyStimulus(idleStim());
    checkOutput("sat_count", obsCount, 32'hFFFF_FFFF);

    // Randomized traffic with legal HI/LO issue.
    resetCycle();
    for (int n = 0; n < 400; n++) begin
      s = idleStim();
      s.rst   = ($urandom_range(0, 59) == 0);
      s.rsA   = 5'($urandom_range(0, 3));
      s.rtA   = 5'($urandom_range(0, 3));
      s.rsU   = 4'($urandom_range(0, 4));
      s.rtU   = 4'($urandom_range(0, 4));
      s.eA    = 5'($urandom_range(0, 3));
      s.mA    = 5'($urandom_range(0, 3));
      s.wA    = 5'($urandom_range(0, 3));
      s.eS    = 4'($urandom_range(0, 3));
      s.mS    = 4'($urandom_range(0, 2));
      s.wS    = 4'd0;
      s.mdUse = ($urandom_range(0, 2) == 0);
      s.mdDiv = 1'($urandom_range(0, 1));
      s.mdStart = (cycleNo > busyEnd) && ($urandom_range(0, 7) == 0);
      applyStimulus(s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
